reg_fifo_ctrl: RTL and testbench
================================

Name: reg_fifo_ctrl

Overview:
- Controller that turns the 2^ADDR_WIDTH x DATA_WIDTH reg_file into a first-word-fall-through FIFO.
- Owns the write/read pointers and drives reg_file wr_en/wr_addr/rd_addr. Data flows directly between the client and reg_file wr_data/rd_data.
- Reports occupancy, threshold flags and sticky error flags. Integrated with reg_file in the wrapper reg_fifo.

Parameters:
- ADDR_WIDTH, 2, pointer width; depth DEPTH = 2**ADDR_WIDTH.
- AF_THRESH, 3, almost_full asserted when level >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserted when level <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr  in  1  push request.
- rd  in  1  pop request.
- clr_err  in  1  clears overflow/underflow sticky flags.
- wr_en  out  1  write strobe to reg_file.
- wr_addr  out  ADDR_WIDTH  write pointer to reg_file.
- rd_addr  out  ADDR_WIDTH  read pointer to reg_file; head entry is visible on rd_data whenever empty=0.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: push was refused.
- underflow  out  1  sticky flag: pop was refused.
- hwm  out  ADDR_WIDTH+1  high-water mark (optional feature).

Behaviour:
- Reset (synchronous, takes priority over everything):
  - wr_addr = rd_addr = 0, level = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0 (for the legal AF_THRESH range).
  - overflow = underflow = 0, hwm = 0.
  - A push or pop in the reset cycle is discarded. Reset mid-stream discards all contents; stored data is not cleared.
- Status state machine (enum in package): ST_EMPTY, ST_PARTIAL, ST_FULL.
  - ST_EMPTY -> ST_PARTIAL on accepted push.
  - ST_PARTIAL -> ST_FULL on a push-only with level == DEPTH-1.
  - ST_PARTIAL -> ST_EMPTY on a pop-only with level == 1.
  - ST_FULL -> ST_PARTIAL on an accepted pop-only.
  - Simultaneous push+pop in ST_PARTIAL or ST_FULL: state and level unchanged.
  - full/empty are registered decodes of the state.
- Accepted push: push_ok = wr & (~full | rd).
  - wr_en = push_ok, combinational, same cycle.
  - wr_addr increments at the edge, wrapping DEPTH-1 -> 0 (natural ADDR_WIDTH overflow).
- Accepted pop: pop_ok = rd & ~empty.
  - rd_addr increments at the edge with the same wrap.
  - Popped data is rd_data in the same cycle (zero latency). The new head is visible the next cycle.
- Level update:
  - level += 1 on push-only, level -= 1 on pop-only.
  - Unchanged on push+pop or no operation.
  - level is never allowed to exceed DEPTH or go below 0.
- Boundary cases:
  - Push+pop when full: both accepted. reg_file reads the old entry combinationally while the same slot is overwritten at the edge.
  - Push+pop when empty: only the push is accepted, and underflow is set.
- Errors:
  - overflow set when wr & full & ~rd.
  - underflow set when rd & empty.
  - Both hold until clr_err or reset. If clr_err and a new error occur in the same cycle, the set wins.
- Threshold flags: almost_full and almost_empty are registered, computed from next-level, so they align with level.

Optional Feature:
- Macro REG_FIFO_CTRL_HWM_EN.
- Defined:
  - hwm register holds the maximum level seen since reset.
  - Updated when next-level > hwm.
  - clr_err also clears hwm to the current level.
- Undefined: hwm is tied to 0 and no register is inferred. The port is always present.

Decomposition:
- Package reg_fifo_pkg holds:
  - status enum fifo_state_t {ST_EMPTY, ST_PARTIAL, ST_FULL};
  - the level-width helper function;
  - the default threshold constants.
- Sub-module fifo_ptr: wrap-around ADDR_WIDTH pointer with increment enable and synchronous reset, instantiated twice (write and read).

Test Plan (defaults: DEPTH=4, AF_THRESH=3, AE_THRESH=1; reg_fifo wrapper with DATA_WIDTH=8):
- Reset, then push 0x11, 0x22, 0x33, 0x44 -> level 1,2,3,4. almost_full at level 3. full=1 after the 4th push. wr_addr wraps to 0. overflow=0.
- 5th push 0x55 while full -> wr_en=0, overflow=1, level stays 4. Pop 4 times -> rd_data 0x11, 0x22, 0x33, 0x44 in order, then empty=1.
- Pop while empty -> underflow=1, rd_addr unchanged. Pulse clr_err -> overflow=underflow=0.
- Full FIFO, push 0x66 and pop in the same cycle -> rd_data 0x11, level stays 4, next pops give 0x22, 0x33, 0x44, 0x66.
- Empty FIFO, push 0x77 and pop in the same cycle -> level=1, underflow=1. Next cycle rd_data=0x77.
- Push 3 entries, assert reset with wr=1 -> level=0, empty=1, pointers 0, hwm=0. With REG_FIFO_CTRL_HWM_EN, hwm=3 before the reset; without it, hwm is always 0.

Source files
------------

// File: rtl/reg_fifo_pkg.sv
// Shared types and constants for the reg_file-backed FIFO controller.
package reg_fifo_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } fifo_state_t;

  localparam int unsigned DEF_AF_THRESH = 3;
  localparam int unsigned DEF_AE_THRESH = 1;

  // Occupancy counts 0..DEPTH, so one bit wider than the pointers.
  function automatic int unsigned level_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer with increment enable and synchronous active-high reset.
module fifo_ptr #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/reg_fifo_ctrl.sv
// First-word-fall-through FIFO controller for reg_file: pointers, level, flags.
// Define REG_FIFO_CTRL_HWM_EN to enable the high-water-mark register.
module reg_fifo_ctrl
  import reg_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned AF_THRESH  = DEF_AF_THRESH,
  parameter int unsigned AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   hwm
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LW    = level_width(ADDR_WIDTH);

  fifo_state_t   state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          af_q, af_d, ae_q, ae_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          push_ok, pop_ok;

  always_comb begin
    // Push is allowed into a full FIFO when a pop frees the same slot this cycle.
    push_ok = wr & (~full_q | rd);
    pop_ok  = rd & ~empty_q;

    level_d = level_q;
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: ;
    endcase

    state_d = state_q;
    unique case (state_q)
      ST_EMPTY:   if (push_ok) state_d = ST_PARTIAL;
      ST_PARTIAL: begin
        if (push_ok && !pop_ok && level_q == LW'(DEPTH - 1))  state_d = ST_FULL;
        else if (pop_ok && !push_ok && level_q == LW'(1))     state_d = ST_EMPTY;
      end
      ST_FULL:    if (pop_ok && !push_ok) state_d = ST_PARTIAL;
      default:    state_d = ST_EMPTY;
    endcase

    full_d  = (state_d == ST_FULL);
    empty_d = (state_d == ST_EMPTY);
    af_d    = (level_d >= LW'(AF_THRESH));
    ae_d    = (level_d <= LW'(AE_THRESH));

    // A new error in the same cycle as clr_err wins.
    ovf_d = (wr & full_q & ~rd) | (ovf_q & ~clr_err);
    udf_d = (rd & empty_q) | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  fifo_ptr #(
    .WIDTH (ADDR_WIDTH)
  ) u_wr_ptr (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (push_ok),
    .ptr_o   (wr_addr)
  );

  fifo_ptr #(
    .WIDTH (ADDR_WIDTH)
  ) u_rd_ptr (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (pop_ok),
    .ptr_o   (rd_addr)
  );

`ifdef REG_FIFO_CTRL_HWM_EN
  logic [LW-1:0] hwm_q, hwm_d, hwm_base;

  always_comb begin
    hwm_base = clr_err ? level_q : hwm_q;
    hwm_d    = (level_d > hwm_base) ? level_d : hwm_base;
  end

  always_ff @(posedge clk) begin
    if (reset) hwm_q <= '0;
    else       hwm_q <= hwm_d;
  end

  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

  assign wr_en        = push_ok;
  assign level        = level_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_reg_fifo_ctrl.sv
// Bench for reg_fifo_ctrl: queue-based reference model, directed pins, random traffic.
module tb_reg_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          reset, wr, rd, clr_err;
  logic [7:0]    wr_data;
  logic          wr_en, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0]   level, hwm;

  int checks   = 0;
  int failures = 0;

  reg_fifo_ctrl #(
    .ADDR_WIDTH (AW),
    .AF_THRESH  (AF),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .clr_err      (clr_err),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
    .hwm          (hwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reg_file stand-in, plus the reference model
  logic [7:0] mem [DEPTH];
  logic [7:0] m_q [$];
  int         m_wc, m_rc, m_hwm;
  bit         m_ovf, m_udf, m_valid = 0;

  always @(posedge clk) begin
    int  sz, base;
    bit  push, pop;
    if (wr_en) mem[wr_addr] = wr_data;
    if (reset) begin
      m_q.delete();
      m_wc = 0; m_rc = 0; m_hwm = 0;
      m_ovf = 0; m_udf = 0;
      m_valid = 1;
    end else begin
      sz    = m_q.size();
      push  = wr && (sz < DEPTH || rd);
      pop   = rd && sz > 0;
      m_ovf = (wr && sz == DEPTH && !rd) || (m_ovf && !clr_err);
      m_udf = (rd && sz == 0) || (m_udf && !clr_err);
      if (pop) begin
        void'(m_q.pop_front());
        m_rc++;
      end
      if (push) begin
        m_q.push_back(wr_data);
        m_wc++;
      end
      base  = clr_err ? sz : m_hwm;
      m_hwm = (m_q.size() > base) ? m_q.size() : base;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("level", level, m_q.size());
      chk("full", full, m_q.size() == DEPTH);
      chk("empty", empty, m_q.size() == 0);
      chk("almost_full", almost_full, m_q.size() >= AF);
      chk("almost_empty", almost_empty, m_q.size() <= AE);
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_udf);
      chk("wr_addr", wr_addr, m_wc % DEPTH);
      chk("rd_addr", rd_addr, m_rc % DEPTH);
`ifdef REG_FIFO_CTRL_HWM_EN
      chk("hwm", hwm, m_hwm);
`else
      chk("hwm", hwm, 0);
`endif
      if (!reset) chk("wr_en", wr_en, wr && (m_q.size() < DEPTH || rd));
      if (m_q.size() > 0) chk("head_data", mem[rd_addr], m_q[0]);
    end
  end

  task automatic setin(input logic w, input logic r, input logic c, input logic rs,
                       input logic [7:0] d);
    wr = w; rd = r; clr_err = c; reset = rs; wr_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic c, input logic rs,
                       input logic [7:0] d);
    setin(w, r, c, rs, d);
    tick();
  endtask

  logic [7:0] exp_data [5];

  initial begin
    setin(0, 0, 0, 1, 8'h00);
    tick();
    tick();
    drive(0, 0, 0, 0, 8'h00);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_hwm", hwm, 0);

    drive(1, 0, 0, 0, 8'h11);
    chk("push1_level", level, 1);
    drive(1, 0, 0, 0, 8'h22);
    chk("push2_level", level, 2);
    drive(1, 0, 0, 0, 8'h33);
    chk("push3_level", level, 3);
    chk("push3_af", almost_full, 1);
    drive(1, 0, 0, 0, 8'h44);
    chk("push4_full", full, 1);
    chk("push4_wr_addr", wr_addr, 0);
    chk("push4_ovf", overflow, 0);

    setin(1, 0, 0, 0, 8'h55);
    #1;
    chk("push5_wr_en", wr_en, 0);
    tick();
    chk("push5_ovf", overflow, 1);
    chk("push5_level", level, 4);

    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33; exp_data[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      setin(0, 1, 0, 0, 8'h00);
      #1;
      chk("pop_data", mem[rd_addr], exp_data[i]);
      tick();
    end
    chk("drained_empty", empty, 1);

    drive(0, 1, 0, 0, 8'h00);
    chk("udf_set", underflow, 1);
    chk("udf_rd_addr", rd_addr, 0);
    drive(0, 0, 1, 0, 8'h00);
    chk("clr_ovf", overflow, 0);
    chk("clr_udf", underflow, 0);

    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, exp_data[i]);
    setin(1, 1, 0, 0, 8'h66);
    #1;
    chk("full_pp_data", mem[rd_addr], 8'h11);
    tick();
    chk("full_pp_level", level, 4);
    exp_data[0] = 8'h22; exp_data[1] = 8'h33; exp_data[2] = 8'h44; exp_data[3] = 8'h66;
    for (int i = 0; i < 4; i++) begin
      setin(0, 1, 0, 0, 8'h00);
      #1;
      chk("full_pp_pop", mem[rd_addr], exp_data[i]);
      tick();
    end

    drive(1, 1, 0, 0, 8'h77);
    chk("empty_pp_level", level, 1);
    chk("empty_pp_udf", underflow, 1);
    setin(0, 0, 0, 0, 8'h00);
    #1;
    chk("empty_pp_data", mem[rd_addr], 8'h77);
    tick();

    drive(0, 0, 0, 1, 8'h00);
    drive(1, 0, 0, 0, 8'hA1);
    drive(1, 0, 0, 0, 8'hA2);
    drive(1, 0, 0, 0, 8'hA3);
`ifdef REG_FIFO_CTRL_HWM_EN
    chk("hwm_before_rst", hwm, 3);
`else
    chk("hwm_before_rst", hwm, 0);
`endif
    drive(1, 0, 0, 1, 8'hA4);
    chk("midrst_level", level, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_hwm", hwm, 0);

    for (int b = 0; b < 60; b++) begin
      for (int i = 0; i < 50; i++) begin
        logic w, r;
        w = ($urandom_range(0, 99) < ((b % 2) ? 75 : 30));
        r = ($urandom_range(0, 99) < ((b % 2) ? 30 : 75));
        drive(w, r, $urandom_range(0, 99) < 4, $urandom_range(0, 199) == 0,
              8'($urandom));
      end
    end

    drive(0, 0, 0, 0, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
